// File: rtl/ex_stage_pkg.sv
// Shared encodings and widths for the execute stage and its divider.
package ex_stage_pkg;

  localparam int unsigned REG_W      = 32;
  localparam int unsigned DREG_W     = 64;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned ALUOP_W    = 8;
  localparam int unsigned ALUSEL_W   = 3;

  localparam logic [REG_W-1:0] ZERO_WORD = '0;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_NOP   = 8'b0000_0000,
    ALU_SRL   = 8'b0000_0010,
    ALU_SRA   = 8'b0000_0011,
    ALU_MFHI  = 8'b0001_0000,
    ALU_MTHI  = 8'b0001_0001,
    ALU_MFLO  = 8'b0001_0010,
    ALU_MTLO  = 8'b0001_0011,
    ALU_MULT  = 8'b0001_1000,
    ALU_MULTU = 8'b0001_1001,
    ALU_DIV   = 8'b0001_1010,
    ALU_DIVU  = 8'b0001_1011,
    ALU_ADD   = 8'b0010_0000,
    ALU_ADDU  = 8'b0010_0001,
    ALU_SUB   = 8'b0010_0010,
    ALU_SUBU  = 8'b0010_0011,
    ALU_AND   = 8'b0010_0100,
    ALU_OR    = 8'b0010_0101,
    ALU_XOR   = 8'b0010_0110,
    ALU_NOR   = 8'b0010_0111,
    ALU_SLT   = 8'b0010_1010,
    ALU_SLTU  = 8'b0010_1011,
    ALU_SLL   = 8'b0111_1100
  } aluop_e;

  typedef enum logic [ALUSEL_W-1:0] {
    SEL_NOP         = 3'b000,
    SEL_LOGIC       = 3'b001,
    SEL_SHIFT       = 3'b010,
    SEL_MOVE        = 3'b011,
    SEL_ARITH       = 3'b100,
    SEL_MUL         = 3'b101,
    SEL_JUMP_BRANCH = 3'b110
  } alusel_e;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX -> EX -> EX/MEM signal bundle; ovf_o exists only with OVERFLOW_TRAP_EN.
interface ex_stage_if;
  import ex_stage_pkg::*;

  logic [REG_W-1:0]      reg1_i;
  logic [REG_W-1:0]      reg2_i;
  logic [REG_ADDR_W-1:0] waddr_i;
  logic                  we_i;
  logic [ALUOP_W-1:0]    aluop_i;
  logic [ALUSEL_W-1:0]   alusel_i;
  logic [REG_W-1:0]      link_addr_i;
  logic                  is_in_delayslot_i;
  logic [REG_W-1:0]      hi_i;
  logic [REG_W-1:0]      lo_i;
  logic                  mem_whilo_i;
  logic [REG_W-1:0]      mem_hi_i;
  logic [REG_W-1:0]      mem_lo_i;
  logic                  wb_whilo_i;
  logic [REG_W-1:0]      wb_hi_i;
  logic [REG_W-1:0]      wb_lo_i;
  logic                  annul_i;

  logic [REG_ADDR_W-1:0] waddr_o;
  logic                  we_o;
  logic [REG_W-1:0]      wdata_o;
  logic                  whilo_o;
  logic [REG_W-1:0]      hi_o;
  logic [REG_W-1:0]      lo_o;
  logic                  stallreq_o;
  logic                  is_in_delayslot_o;
`ifdef OVERFLOW_TRAP_EN
  logic                  ovf_o;
`endif

  modport slave (
    input  reg1_i, reg2_i, waddr_i, we_i, aluop_i, alusel_i, link_addr_i,
           is_in_delayslot_i, hi_i, lo_i, mem_whilo_i, mem_hi_i, mem_lo_i,
           wb_whilo_i, wb_hi_i, wb_lo_i, annul_i,
`ifdef OVERFLOW_TRAP_EN
    output ovf_o,
`endif
    output waddr_o, we_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o,
           is_in_delayslot_o
  );

  modport master (
    output reg1_i, reg2_i, waddr_i, we_i, aluop_i, alusel_i, link_addr_i,
           is_in_delayslot_i, hi_i, lo_i, mem_whilo_i, mem_hi_i, mem_lo_i,
           wb_whilo_i, wb_hi_i, wb_lo_i, annul_i,
`ifdef OVERFLOW_TRAP_EN
    input  ovf_o,
`endif
    input  waddr_o, we_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o,
           is_in_delayslot_o
  );

endinterface

// File: rtl/ex_stage_div_unit.sv
// Iterative radix-2 restoring divider: one quotient bit per cycle, signed
// results fixed up from latched sign flags when the result is presented.
module div_unit
  import ex_stage_pkg::*;
#(
  parameter int unsigned DATA_W    = REG_W,
  parameter int unsigned DIV_STEPS = DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam int unsigned CNT_W = $clog2(DIV_STEPS);

  div_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic              quo_neg_q, quo_neg_d;
  logic              rem_neg_q, rem_neg_d;

  logic [DATA_W:0]   rem_shift;
  logic [DATA_W:0]   trial;

  function automatic logic [DATA_W-1:0] twos_neg(input logic [DATA_W-1:0] x);
    return ~x + DATA_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DIV_FREE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
    end
  end

  // quo_q holds the dividend magnitude at start and shifts quotient bits in from the right
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    ready_o   = 1'b0;
    result_o  = '0;
    rem_shift = {rem_q, quo_q[DATA_W-1]};
    trial     = rem_shift - {1'b0, dvs_q};

    case (state_q)
      DIV_FREE: begin
        if (start_i) begin
          cnt_d = '0;
          rem_d = '0;
          if (opdata2_i == '0) begin
            state_d   = DIV_BY_ZERO;
            quo_d     = '0;
            dvs_d     = '0;
            quo_neg_d = 1'b0;
            rem_neg_d = 1'b0;
          end else begin
            state_d   = DIV_ON;
            quo_d     = (signed_i && opdata1_i[DATA_W-1]) ? twos_neg(opdata1_i) : opdata1_i;
            dvs_d     = (signed_i && opdata2_i[DATA_W-1]) ? twos_neg(opdata2_i) : opdata2_i;
            quo_neg_d = signed_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
            rem_neg_d = signed_i && opdata1_i[DATA_W-1];
          end
        end
      end
      DIV_BY_ZERO: state_d = DIV_END;
      DIV_ON: begin
        if (!trial[DATA_W]) begin
          rem_d = trial[DATA_W-1:0];
          quo_d = {quo_q[DATA_W-2:0], 1'b1};
        end else begin
          rem_d = rem_shift[DATA_W-1:0];
          quo_d = {quo_q[DATA_W-2:0], 1'b0};
        end
        if (cnt_q == CNT_W'(DIV_STEPS - 1)) begin
          state_d = DIV_END;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DIV_END: begin
        ready_o  = 1'b1;
        result_o = {rem_neg_q ? twos_neg(rem_q) : rem_q,
                    quo_neg_q ? twos_neg(quo_q) : quo_q};
        state_d  = DIV_FREE;
      end
      default: state_d = DIV_FREE;
    endcase

    if (annul_i) begin
      state_d  = DIV_FREE;
      ready_o  = 1'b0;
      result_o = '0;
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Pipeline execute stage: ALU, HI/LO forwarding, multiply and iterative divide.
// Optional OVERFLOW_TRAP_EN adds signed overflow detection on ADD/SUB (ovf_o).
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int unsigned DATA_W    = REG_W,
  parameter int unsigned DIV_STEPS = DATA_W
) (
  input  logic       clk,
  input  logic       rst,
  ex_stage_if.slave  bus
);

  logic [REG_W-1:0]    hi_fwd, lo_fwd;
  logic [REG_W-1:0]    logic_res, shift_res, arith_res, move_res;
  logic [REG_W-1:0]    sum, dif;
  logic [DREG_W-1:0]   mul_a, mul_b, prod;
  logic                mul_signed;
  logic                is_div, div_start, div_signed, div_ready;
  logic [2*DATA_W-1:0] div_result;
`ifdef OVERFLOW_TRAP_EN
  logic                add_ovf, sub_ovf;
`endif

  // Newest HI/LO write in flight wins over the architectural copy
  always_comb begin
    if (bus.mem_whilo_i) begin
      hi_fwd = bus.mem_hi_i;
      lo_fwd = bus.mem_lo_i;
    end else if (bus.wb_whilo_i) begin
      hi_fwd = bus.wb_hi_i;
      lo_fwd = bus.wb_lo_i;
    end else begin
      hi_fwd = bus.hi_i;
      lo_fwd = bus.lo_i;
    end
  end

  always_comb begin
    logic_res = ZERO_WORD;
    shift_res = ZERO_WORD;
    move_res  = ZERO_WORD;
    case (bus.aluop_i)
      ALU_OR:   logic_res = bus.reg1_i | bus.reg2_i;
      ALU_AND:  logic_res = bus.reg1_i & bus.reg2_i;
      ALU_XOR:  logic_res = bus.reg1_i ^ bus.reg2_i;
      ALU_NOR:  logic_res = ~(bus.reg1_i | bus.reg2_i);
      ALU_SLL:  shift_res = bus.reg2_i << bus.reg1_i[4:0];
      ALU_SRL:  shift_res = bus.reg2_i >> bus.reg1_i[4:0];
      ALU_SRA:  shift_res = $signed(bus.reg2_i) >>> bus.reg1_i[4:0];
      ALU_MFHI: move_res  = hi_fwd;
      ALU_MFLO: move_res  = lo_fwd;
      default: ;
    endcase
  end

  assign sum = bus.reg1_i + bus.reg2_i;
  assign dif = bus.reg1_i - bus.reg2_i;

`ifdef OVERFLOW_TRAP_EN
  assign add_ovf = (bus.reg1_i[REG_W-1] == bus.reg2_i[REG_W-1]) && (sum[REG_W-1] != bus.reg1_i[REG_W-1]);
  assign sub_ovf = (bus.reg1_i[REG_W-1] != bus.reg2_i[REG_W-1]) && (dif[REG_W-1] != bus.reg1_i[REG_W-1]);
`endif

  always_comb begin
    arith_res = ZERO_WORD;
    case (bus.aluop_i)
      ALU_ADD, ALU_ADDU: arith_res = sum;
      ALU_SUB, ALU_SUBU: arith_res = dif;
      ALU_SLT:  arith_res = REG_W'($signed(bus.reg1_i) < $signed(bus.reg2_i));
      ALU_SLTU: arith_res = REG_W'(bus.reg1_i < bus.reg2_i);
      default: ;
    endcase
  end

  // Low 64 bits of the extended product are correct for both signednesses
  assign mul_signed = (bus.aluop_i == ALU_MULT);
  assign mul_a = mul_signed ? {{REG_W{bus.reg1_i[REG_W-1]}}, bus.reg1_i} : {{REG_W{1'b0}}, bus.reg1_i};
  assign mul_b = mul_signed ? {{REG_W{bus.reg2_i[REG_W-1]}}, bus.reg2_i} : {{REG_W{1'b0}}, bus.reg2_i};
  assign prod  = mul_a * mul_b;

  assign is_div     = (bus.aluop_i == ALU_DIV) || (bus.aluop_i == ALU_DIVU);
  assign div_start  = is_div && !bus.annul_i;
  assign div_signed = (bus.aluop_i == ALU_DIV);

  div_unit #(
    .DATA_W    (DATA_W),
    .DIV_STEPS (DIV_STEPS)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .signed_i  (div_signed),
    .opdata1_i (bus.reg1_i),
    .opdata2_i (bus.reg2_i),
    .start_i   (div_start),
    .annul_i   (bus.annul_i),
    .result_o  (div_result),
    .ready_o   (div_ready)
  );

  always_comb begin
    bus.waddr_o           = '0;
    bus.we_o              = 1'b0;
    bus.wdata_o           = ZERO_WORD;
    bus.whilo_o           = 1'b0;
    bus.hi_o              = ZERO_WORD;
    bus.lo_o              = ZERO_WORD;
    bus.stallreq_o        = 1'b0;
    bus.is_in_delayslot_o = 1'b0;
`ifdef OVERFLOW_TRAP_EN
    bus.ovf_o             = 1'b0;
`endif
    if (!rst) begin
      bus.waddr_o           = bus.waddr_i;
      bus.we_o              = bus.we_i;
      bus.is_in_delayslot_o = bus.is_in_delayslot_i;

      case (bus.alusel_i)
        SEL_LOGIC:       bus.wdata_o = logic_res;
        SEL_SHIFT:       bus.wdata_o = shift_res;
        SEL_ARITH:       bus.wdata_o = arith_res;
        SEL_MOVE:        bus.wdata_o = move_res;
        SEL_MUL:         bus.wdata_o = prod[REG_W-1:0];
        SEL_JUMP_BRANCH: bus.wdata_o = bus.link_addr_i;
        default: ;
      endcase

      case (bus.aluop_i)
        ALU_MULT, ALU_MULTU: begin
          bus.whilo_o = 1'b1;
          bus.hi_o    = prod[DREG_W-1:REG_W];
          bus.lo_o    = prod[REG_W-1:0];
        end
        ALU_DIV, ALU_DIVU: begin
          bus.whilo_o    = div_ready;
          bus.hi_o       = div_result[2*DATA_W-1:DATA_W];
          bus.lo_o       = div_result[DATA_W-1:0];
          bus.stallreq_o = !bus.annul_i && !div_ready;
        end
        ALU_MTHI: begin
          bus.whilo_o = 1'b1;
          bus.hi_o    = bus.reg1_i;
          bus.lo_o    = lo_fwd;
        end
        ALU_MTLO: begin
          bus.whilo_o = 1'b1;
          bus.hi_o    = hi_fwd;
          bus.lo_o    = bus.reg1_i;
        end
        default: ;
      endcase

`ifdef OVERFLOW_TRAP_EN
      if ((bus.aluop_i == ALU_ADD && add_ovf) || (bus.aluop_i == ALU_SUB && sub_ovf)) begin
        bus.we_o  = 1'b0;
        bus.ovf_o = 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  ex_stage_if bus();

  ex_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input aluop_e op, input alusel_e sel, input logic [31:0] a, input logic [31:0] b);
    bus.aluop_i  = op;
    bus.alusel_i = sel;
    bus.reg1_i   = a;
    bus.reg2_i   = b;
  endtask

  // Drives a divide and walks it to completion, counting stall cycles
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input int exp_stalls, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input bit perturb);
    int stalls = 0;
    bit done   = 1'b0;
    set_op(sgn ? ALU_DIV : ALU_DIVU, SEL_NOP, a, b);
    bus.we_i = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      #1;
      if (bus.stallreq_o === 1'b1) begin
        stalls++;
        if (perturb && stalls == 5) begin
          bus.reg1_i = 32'h1234_5678;
          bus.reg2_i = 32'h0000_0009;
        end
        @(posedge clk);
        #1;
      end else begin
        done = 1'b1;
      end
    end
    check32({tag, "_stalls"}, 32'(stalls), 32'(exp_stalls));
    check1({tag, "_whilo"}, bus.whilo_o, 1'b1);
    check32({tag, "_hi"}, bus.hi_o, exp_hi);
    check32({tag, "_lo"}, bus.lo_o, exp_lo);
    next_cycle();
  endtask

  initial begin
    int stalls;
    rst                   = 1'b1;
    bus.reg1_i            = 32'h0000_F0F0;
    bus.reg2_i            = 32'h0000_0F0F;
    bus.waddr_i           = 5'd3;
    bus.we_i              = 1'b1;
    bus.aluop_i           = ALU_OR;
    bus.alusel_i          = SEL_LOGIC;
    bus.link_addr_i       = 32'h0000_0400;
    bus.is_in_delayslot_i = 1'b1;
    bus.hi_i              = 32'h0000_000C;
    bus.lo_i              = 32'h0000_0000;
    bus.mem_whilo_i       = 1'b0;
    bus.mem_hi_i          = 32'h0000_000A;
    bus.mem_lo_i          = 32'h0;
    bus.wb_whilo_i        = 1'b0;
    bus.wb_hi_i           = 32'h0000_000B;
    bus.wb_lo_i           = 32'h0;
    bus.annul_i           = 1'b0;

    #1;
    check32("rst_wdata", bus.wdata_o, 32'h0);
    check1("rst_we", bus.we_o, 1'b0);
    check1("rst_stall", bus.stallreq_o, 1'b0);
    check1("rst_dslot", bus.is_in_delayslot_o, 1'b0);
    next_cycle();
    next_cycle();
    rst = 1'b0;

    #1;
    check32("or_wdata", bus.wdata_o, 32'h0000_FFFF);
    check1("or_we", bus.we_o, 1'b1);
    check32("or_waddr", 32'(bus.waddr_o), 32'd3);
    check1("dslot", bus.is_in_delayslot_o, 1'b1);
    check1("or_whilo", bus.whilo_o, 1'b0);

    next_cycle();
    set_op(ALU_SRA, SEL_SHIFT, 32'd4, 32'h8000_0000);
    #1 check32("sra", bus.wdata_o, 32'hF800_0000);
    set_op(ALU_SLL, SEL_SHIFT, 32'd31, 32'h0000_0003);
    #1 check32("sll", bus.wdata_o, 32'h8000_0000);
    set_op(ALU_SLT, SEL_ARITH, 32'hFFFF_FFFF, 32'd1);
    #1 check32("slt", bus.wdata_o, 32'd1);
    set_op(ALU_SLTU, SEL_ARITH, 32'hFFFF_FFFF, 32'd1);
    #1 check32("sltu", bus.wdata_o, 32'd0);
    set_op(ALU_SUBU, SEL_ARITH, 32'd5, 32'd7);
    #1 check32("subu", bus.wdata_o, 32'hFFFF_FFFE);
    set_op(ALU_NOR, SEL_LOGIC, 32'hFFFF_0000, 32'h00FF_0000);
    #1 check32("nor", bus.wdata_o, 32'h0000_FFFF);

    set_op(ALU_MULT, SEL_NOP, 32'hFFFF_FFFE, 32'd3);
    #1;
    check32("mult_hi", bus.hi_o, 32'hFFFF_FFFF);
    check32("mult_lo", bus.lo_o, 32'hFFFF_FFFA);
    check1("mult_whilo", bus.whilo_o, 1'b1);
    set_op(ALU_MULTU, SEL_NOP, 32'hFFFF_FFFE, 32'd3);
    #1 check32("multu_hi", bus.hi_o, 32'h0000_0002);

    set_op(ALU_MFHI, SEL_MOVE, 32'h0, 32'h0);
    bus.mem_whilo_i = 1'b1;
    bus.wb_whilo_i  = 1'b1;
    #1 check32("mfhi_mem", bus.wdata_o, 32'h0000_000A);
    bus.mem_whilo_i = 1'b0;
    #1 check32("mfhi_wb", bus.wdata_o, 32'h0000_000B);
    bus.wb_whilo_i = 1'b0;
    #1 check32("mfhi_arch", bus.wdata_o, 32'h0000_000C);

    set_op(ALU_MTLO, SEL_NOP, 32'h0000_1234, 32'h0);
    #1;
    check1("mtlo_whilo", bus.whilo_o, 1'b1);
    check32("mtlo_lo", bus.lo_o, 32'h0000_1234);
    check32("mtlo_hi", bus.hi_o, 32'h0000_000C);

    set_op(ALU_NOP, SEL_JUMP_BRANCH, 32'h0, 32'h0);
    #1 check32("link", bus.wdata_o, 32'h0000_0400);
    bus.aluop_i  = 8'hFF;
    bus.alusel_i = SEL_LOGIC;
    #1;
    check32("unk_wdata", bus.wdata_o, 32'h0);
    check1("unk_whilo", bus.whilo_o, 1'b0);

    bus.we_i = 1'b1;
    set_op(ALU_ADD, SEL_ARITH, 32'h7FFF_FFFF, 32'd1);
    #1;
    check32("add_wdata", bus.wdata_o, 32'h8000_0000);
`ifdef OVERFLOW_TRAP_EN
    check1("add_ovf_we", bus.we_o, 1'b0);
    check1("add_ovf", bus.ovf_o, 1'b1);
    set_op(ALU_ADDU, SEL_ARITH, 32'h7FFF_FFFF, 32'd1);
    #1;
    check1("addu_we", bus.we_o, 1'b1);
    check1("addu_ovf", bus.ovf_o, 1'b0);
`else
    check1("add_we", bus.we_o, 1'b1);
`endif

    next_cycle();
    run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);
    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 33, 32'd2, 32'd14, 1'b0);
    run_div("divu_by0", 1'b0, 32'd5, 32'd0, 2, 32'd0, 32'd0, 1'b0);

    set_op(ALU_DIV, SEL_NOP, 32'd50, 32'd3);
    stalls = 0;
    for (int c = 0; c < 11; c++) begin
      #1;
      if (bus.stallreq_o === 1'b1) stalls++;
      next_cycle();
    end
    bus.annul_i = 1'b1;
    #1;
    check32("annul_pre_stalls", 32'(stalls), 32'd11);
    check1("annul_stall", bus.stallreq_o, 1'b0);
    check1("annul_whilo", bus.whilo_o, 1'b0);
    next_cycle();
    bus.annul_i = 1'b0;
    run_div("div_after_annul", 1'b1, 32'hFFFF_FF9C, 32'd7, 33, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0);

    bus.aluop_i = ALU_NOP;
    #1 check1("idle_stall", bus.stallreq_o, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
